// File: rtl/sd_burst_manager.sv
`default_nettype none
// ============================================================================
// Module   : sd_burst_manager
// Function : READSD/WRITESD burst engine. Moves WORD_BYTES bytes over a
//            request/acknowledge SD port and writes reads back as one word.
// Revision : 1.0 - initial release
// ============================================================================
module sd_burst_manager #(
    parameter int          WORD_BYTES = 4,
    parameter int          TIMEOUT_W  = 16,
    parameter logic [31:0] ERR_VALUE  = 32'hFFFF_FFFF,
    parameter logic [5:0]  READSD_OP  = 6'h38,
    parameter logic [5:0]  WRITESD_OP = 6'h39
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        stall,
    output logic        enable,
    output logic        float,
    output logic [4:0]  addr,
    output logic [31:0] data,
    output logic        err,
    input  logic [7:0]  sd_read_data,
    output logic [7:0]  sd_write_data,
    output logic [31:0] sd_addr,
    output logic        sd_read,
    output logic        sd_write,
    input  logic        sd_ready
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    localparam logic [1:0]           c_LAST_IDX  = 2'(WORD_BYTES - 1);
    localparam logic [TIMEOUT_W-1:0] c_TIMER_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] c_TIMER_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [1:0]           r_idx;
    logic [TIMEOUT_W-1:0] r_timer;
    logic                 r_is_read;
    logic [31:0]          r_rs;
    logic [31:0]          r_rt;
    logic [31:0]          r_word;

    logic                 w_op_read;
    logic                 w_op_write;
    logic                 w_is_sd;
    logic                 w_handshake;
    logic [TIMEOUT_W-1:0] w_timer_inc;
    logic [1:0]           w_idx_next;
    logic                 w_unused;

    assign w_op_read   = (inst[31:26] == READSD_OP);
    assign w_op_write  = (inst[31:26] == WRITESD_OP);
    assign w_is_sd     = w_op_read | w_op_write;
    assign w_timer_inc = r_timer + c_TIMER_ONE;
    assign w_idx_next  = r_idx + 2'd1;
    // An edge of interest: acknowledge while requesting, or its release afterwards.
    assign w_handshake = ((r_state == c_REQ) && sd_ready) ||
                         ((r_state == c_RELEASE) && !sd_ready);
    assign w_unused    = ^{inst[25:21], inst[15:0]};

    // The IDLE term holds the CPU in the very cycle the instruction is issued.
    assign stall = ((r_state != c_IDLE) && (r_state != c_DONE)) ||
                   ((r_state == c_IDLE) && w_is_sd);
    assign float = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_idx         <= 2'd0;
            r_timer       <= '0;
            r_is_read     <= 1'b0;
            r_rs          <= 32'd0;
            r_rt          <= 32'd0;
            r_word        <= 32'd0;
            err           <= 1'b0;
            enable        <= 1'b0;
            addr          <= 5'd0;
            data          <= 32'd0;
            sd_read       <= 1'b0;
            sd_write      <= 1'b0;
            sd_addr       <= 32'd0;
            sd_write_data <= 8'd0;
        end else begin
            enable <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_is_sd) begin
                        r_is_read     <= w_op_read;
                        r_rs          <= rs;
                        r_rt          <= rt;
                        addr          <= inst[20:16];
                        r_idx         <= 2'd0;
                        r_timer       <= '0;
                        r_word        <= 32'd0;
                        sd_addr       <= rs;
                        sd_write_data <= rt[7:0];
                        sd_read       <= w_op_read;
                        sd_write      <= w_op_write;
                        r_state       <= c_REQ;
                    end
                end
                c_REQ, c_RELEASE: begin
                    if (!w_handshake) begin
                        if (w_timeout_hit(w_timer_inc)) begin
                            err      <= 1'b1;
                            sd_read  <= 1'b0;
                            sd_write <= 1'b0;
                            enable   <= r_is_read;
                            if (r_is_read) data <= ERR_VALUE;
                            r_state  <= c_DONE;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end else if (r_state == c_REQ) begin
                        if (r_is_read) r_word[{r_idx, 3'b000} +: 8] <= sd_read_data;
                        sd_read  <= 1'b0;
                        sd_write <= 1'b0;
                        r_timer  <= '0;
                        r_state  <= c_RELEASE;
                    end else if (r_idx == c_LAST_IDX) begin
                        enable  <= r_is_read;
                        if (r_is_read) data <= r_word;
                        r_state <= c_DONE;
                    end else begin
                        r_idx         <= w_idx_next;
                        r_timer       <= '0;
                        sd_addr       <= r_rs + {30'd0, w_idx_next};
                        sd_write_data <= r_rt[{w_idx_next, 3'b000} +: 8];
                        sd_read       <= r_is_read;
                        sd_write      <= !r_is_read;
                        r_state       <= c_REQ;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    function automatic logic w_timeout_hit(input logic [TIMEOUT_W-1:0] next_timer);
        return next_timer == c_TIMER_MAX;
    endfunction

endmodule
`default_nettype wire

// File: tb/tb_sd_burst_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_burst_manager
// Function : Scoreboard bench for sd_burst_manager: a 4-byte instance and a
//            single-byte instance, each served by a behavioural SD card.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_burst_manager;

    localparam logic [5:0] OP_RD = 6'h38;
    localparam logic [5:0] OP_WR = 6'h39;

    typedef struct { logic [4:0] a; logic [31:0] d; } wb_t;
    typedef struct { bit wr; logic [31:0] a; logic [7:0] d; } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst [2];
    logic [31:0] rs [2];
    logic [31:0] rt [2];
    logic        stall [2];
    logic        enable [2];
    logic        flt [2];
    logic        err [2];
    logic [4:0]  addr [2];
    logic [31:0] data [2];
    logic [7:0]  sd_read_data [2];
    logic [7:0]  sd_write_data [2];
    logic [31:0] sd_addr [2];
    logic        sd_read [2];
    logic        sd_write [2];
    logic        sd_ready [2];

    int  ack_dly [2];
    int  hold [2];
    bit  dead [2];
    int  xfers [2];
    wb_t  wb_q [2][$];
    acc_t acc_q [2][$];

    logic [7:0] card  [logic [31:0]];
    logic [7:0] model [logic [31:0]];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        return model.exists(a) ? model[a] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int WB = (g == 0) ? 4 : 1;

        sd_burst_manager #(
            .WORD_BYTES (WB),
            .TIMEOUT_W  (4),
            .ERR_VALUE  (32'hFFFF_FFFF),
            .READSD_OP  (OP_RD),
            .WRITESD_OP (OP_WR)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .inst          (inst[g]),
            .rs            (rs[g]),
            .rt            (rt[g]),
            .stall         (stall[g]),
            .enable        (enable[g]),
            .float         (flt[g]),
            .addr          (addr[g]),
            .data          (data[g]),
            .err           (err[g]),
            .sd_read_data  (sd_read_data[g]),
            .sd_write_data (sd_write_data[g]),
            .sd_addr       (sd_addr[g]),
            .sd_read       (sd_read[g]),
            .sd_write      (sd_write[g]),
            .sd_ready      (sd_ready[g])
        );

        // Write-back monitor.
        always @(negedge clk) begin
            wb_t e;
            if (enable[g]) begin
                if (wb_q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected[%0d]: got enable=1 data=%h, expected no write-back", g, data[g]);
                end else begin
                    e = wb_q[g].pop_front();
                    chk("wb_addr", 64'(addr[g]), 64'(e.a));
                    chk("wb_data", 64'(data[g]), 64'(e.d));
                    chk("stall_in_done", 64'(stall[g]), 64'd0);
                end
            end
            if (sd_read[g] || sd_write[g])
                chk("strobe_excl", 64'(sd_read[g] & sd_write[g]), 64'd0);
        end

        // Behavioural SD card: acknowledge after ack_dly cycles, keep ready up hold cycles after release.
        initial begin
            acc_t        e;
            int          n;
            logic [31:0] a;
            sd_ready[g]     = 1'b0;
            sd_read_data[g] = 8'h00;
            forever begin
                @(posedge clk);
                #1;
                if ((sd_read[g] || sd_write[g]) && !dead[g] && !rst) begin
                    a = sd_addr[g];
                    if (acc_q[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL acc_unexpected[%0d]: got access at %h, expected none", g, a);
                    end else begin
                        e = acc_q[g].pop_front();
                        chk("acc_write", 64'(sd_write[g]), 64'(e.wr));
                        chk("acc_read", 64'(sd_read[g]), 64'(!e.wr));
                        chk("acc_addr", 64'(a), 64'(e.a));
                        if (e.wr) chk("acc_wdata", 64'(sd_write_data[g]), 64'(e.d));
                    end
                    xfers[g]++;
                    repeat (ack_dly[g]) @(posedge clk);
                    #1;
                    if (sd_write[g]) card[a] = sd_write_data[g];
                    sd_read_data[g] = card.exists(a) ? card[a] : dflt(a);
                    sd_ready[g]     = 1'b1;
                    n = 0;
                    do begin
                        @(posedge clk);
                        #1;
                        n++;
                    end while ((sd_read[g] || sd_write[g]) && n < 40);
                    chk("strobe_released", 64'(sd_read[g] | sd_write[g]), 64'd0);
                    repeat (hold[g]) @(posedge clk);
                    #1;
                    sd_ready[g] = 1'b0;
                end
            end
        end
    end

    // Issue one SD instruction on unit u and wait for stall to fall; cyc = stalled cycles.
    task automatic burst(input int u, input bit rd, input logic [31:0] base,
                         input logic [4:0] rf, input logic [31:0] wd,
                         input int a_d, input int h, input bit tmo, output int cyc);
        int          wb;
        logic [31:0] exp;
        logic [31:0] ad;
        acc_t        ac;
        wb_t         w;
        wb  = (u == 0) ? 4 : 1;
        exp = 32'd0;
        ack_dly[u] = a_d;
        hold[u]    = h;
        for (int k = 0; k < wb; k++) begin
            ad = base + 32'(k);
            if (rd) exp[8*k +: 8] = model_rd(ad);
            else    model[ad]     = wd[8*k +: 8];
            ac.wr = !rd;
            ac.a  = ad;
            ac.d  = rd ? 8'h00 : wd[8*k +: 8];
            if (!tmo) acc_q[u].push_back(ac);
        end
        if (rd) begin
            w.a = rf;
            w.d = tmo ? 32'hFFFF_FFFF : exp;
            wb_q[u].push_back(w);
        end
        @(negedge clk);
        inst[u] = {rd ? OP_RD : OP_WR, 5'd0, rf, 16'h0000};
        rs[u]   = base;
        rt[u]   = wd;
        cyc = 0;
        #1;
        while (stall[u] && cyc < 300) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        chk("burst_end", 64'(stall[u]), 64'd0);
        inst[u] = 32'h0;
        if (!tmo) chk("latency", 64'(cyc), 64'(1 + wb * (a_d + h + 2)));
        chk("acc_drained", 64'(acc_q[u].size()), 64'd0);
        chk("wb_drained", 64'(wb_q[u].size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cyc;
        int          n;
        int          x0;
        bit          rd;
        logic [31:0] base;
        acc_t        ac;
        for (int u = 0; u < 2; u++) begin
            inst[u] = 32'h0; rs[u] = 32'h0; rt[u] = 32'h0;
            ack_dly[u] = 0; hold[u] = 0; dead[u] = 1'b0; xfers[u] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_stall", 64'(stall[u]), 64'd0);
            chk("rst_enable", 64'(enable[u]), 64'd0);
            chk("rst_sd_read", 64'(sd_read[u]), 64'd0);
            chk("rst_sd_write", 64'(sd_write[u]), 64'd0);
            chk("rst_sd_addr", 64'(sd_addr[u]), 64'd0);
            chk("rst_sd_wdata", 64'(sd_write_data[u]), 64'd0);
            chk("rst_data", 64'(data[u]), 64'd0);
            chk("rst_addr", 64'(addr[u]), 64'd0);
            chk("rst_err", 64'(err[u]), 64'd0);
            chk("float", 64'(flt[u]), 64'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed 4-byte read.
        for (int k = 0; k < 4; k++) begin
            model[32'h100 + 32'(k)] = 8'(8'h11 * (k + 1));
            card[32'h100 + 32'(k)]  = 8'(8'h11 * (k + 1));
        end
        burst(0, 1'b1, 32'h100, 5'd5, 32'h0, 3, 2, 1'b0, cyc);

        // Directed write, then read it back.
        burst(0, 1'b0, 32'h200, 5'd0, 32'hA1B2_C3D4, 2, 1, 1'b0, cyc);
        burst(0, 1'b1, 32'h200, 5'd8, 32'h0, 0, 0, 1'b0, cyc);

        // Sticky acknowledge: ready stays high five cycles per byte.
        x0 = xfers[0];
        burst(0, 1'b1, 32'h140, 5'd7, 32'h0, 1, 4, 1'b0, cyc);
        chk("sticky_xfers", 64'(xfers[0] - x0), 64'd4);

        // Timeout with a card that never answers.
        dead[0] = 1'b1;
        burst(0, 1'b1, 32'h180, 5'd9, 32'h0, 0, 0, 1'b1, cyc);
        chk("timeout_cycles", 64'(cyc), 64'd16);
        chk("timeout_err", 64'(err[0]), 64'd1);
        chk("timeout_strobe", 64'(sd_read[0] | sd_write[0]), 64'd0);
        dead[0] = 1'b0;
        repeat (2) @(negedge clk);
        burst(0, 1'b0, 32'h1C0, 5'd0, 32'h0102_0304, 1, 1, 1'b0, cyc);
        chk("err_sticky", 64'(err[0]), 64'd1);

        // Reset during the second byte of a read.
        ack_dly[0] = 3;
        hold[0]    = 2;
        for (int k = 0; k < 4; k++) begin
            ac.wr = 1'b0; ac.a = 32'h300 + 32'(k); ac.d = 8'h00;
            acc_q[0].push_back(ac);
        end
        @(negedge clk);
        inst[0] = {OP_RD, 5'd0, 5'd3, 16'h0000};
        rs[0]   = 32'h300;
        n = 0;
        while (!(sd_read[0] && sd_addr[0] == 32'h301) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_byte2", 64'(sd_addr[0]), 64'h301);
        #2;
        rst     = 1'b1;
        inst[0] = 32'h0;
        #1;
        chk("midrst_sd_read", 64'(sd_read[0]), 64'd0);
        chk("midrst_stall", 64'(stall[0]), 64'd0);
        chk("midrst_enable", 64'(enable[0]), 64'd0);
        chk("midrst_err", 64'(err[0]), 64'd0);
        acc_q[0].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        burst(0, 1'b1, 32'h100, 5'd6, 32'h0, 2, 1, 1'b0, cyc);

        // Randomized bursts, including address wrap-around.
        for (int i = 0; i < 20; i++) begin
            rd   = 1'($urandom_range(0, 1));
            base = (i % 5 == 4) ? 32'hFFFF_FFFE : (32'h400 + 32'($urandom_range(0, 24)));
            burst(0, rd, base, 5'($urandom_range(1, 31)), $urandom,
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 5)), 1'b0, cyc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Single-byte unit: a non-SD op first, then reads and writes.
        @(negedge clk);
        inst[1] = {6'h08, 5'd1, 5'd2, 16'h0010};
        #1;
        chk("nonsd_stall", 64'(stall[1]), 64'd0);
        repeat (5) @(negedge clk);
        chk("nonsd_sd_read", 64'(sd_read[1]), 64'd0);
        inst[1] = 32'h0;
        model[32'h50] = 8'h7E;
        card[32'h50]  = 8'h7E;
        burst(1, 1'b1, 32'h50, 5'd12, 32'h0, 1, 1, 1'b0, cyc);
        for (int i = 0; i < 6; i++) begin
            burst(1, 1'($urandom_range(0, 1)), 32'h60 + 32'($urandom_range(0, 3)),
                  5'($urandom_range(1, 31)), $urandom,
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0, cyc);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_burst_manager.md
Name: sd_burst_manager

Overview:
- Successor to the single-byte SD instruction dispatcher.
- Decodes READSD/WRITESD instructions from the CPU and performs a burst of WORD_BYTES byte transfers to or from the SD controller at consecutive byte addresses.
- Stalls the CPU for the whole burst, using a proper request/acknowledge state machine in place of the old ready-history hack.
- Read results go back to the register file as one assembled little-endian word; a bounded timeout keeps a hung card from locking the core.

Parameters:
- WORD_BYTES, 4: bytes per instruction, legal 1..4. Byte k comes from or goes to sd_addr = rs + k.
- TIMEOUT_W, 16: timeout counter width. Timeout occurs when no handshake edge is seen for 2^TIMEOUT_W - 1 cycles.
- ERR_VALUE, 32'hFFFFFFFF: word written back on a read that times out.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- inst  in  32  current instruction. op = inst[31:26]; READSD/WRITESD codes come from the team opcode header.
- rs  in  32  SD base byte address.
- rt  in  32  write data; byte k = rt[8k+7:8k].
- stall  out  1  high while an SD instruction is unfinished; CPU holds inst/rs/rt while high.
- enable  out  1  register write-back strobe, one cycle.
- float  out  1  constant 0.
- addr  out  5  write-back register, latched inst[20:16].
- data  out  32  write-back word.
- err  out  1  sticky timeout flag; cleared only by rst.
- sd_read_data  in  8  byte from the SD controller, valid while sd_ready=1.
- sd_write_data  out  8  byte to the SD controller.
- sd_addr  out  32  SD byte address.
- sd_read  out  1  read request level.
- sd_write  out  1  write request level.
- sd_ready  in  1  SD controller acknowledge level; may stay high for several cycles.

Behaviour:
- Reset values: state=IDLE, idx=0, timer=0, err=0, stall=0, enable=0, sd_read=0, sd_write=0, data=0, addr=0, sd_addr=0, sd_write_data=0. A reset mid-burst aborts immediately: no write-back, strobes drop asynchronously.
- All outputs except stall are registered. stall = (state != IDLE && state != DONE) || (state == IDLE && op is READSD/WRITESD). The combinational IDLE term stops the CPU advancing in the issue cycle.
- IDLE: if op is READSD or WRITESD, latch op, rs, rt, inst[20:16]; set idx=0, timer=0, assembly word=0; go to REQ. Otherwise stay.
- REQ:
  - Drive sd_addr = rs_l + idx (32-bit wrap-around allowed), sd_write_data = rt_l byte idx.
  - Raise sd_read or sd_write according to the latched op; exactly one is ever high.
  - When sd_ready=1: on a read, capture sd_read_data into byte idx; drop the strobe; timer=0; go to RELEASE.
- RELEASE: strobes low. When sd_ready=0:
  - if idx == WORD_BYTES-1, go to DONE;
  - else idx++, timer=0, go to REQ.
- Timeout: timer increments each cycle in REQ or RELEASE. Reaching all-ones sets err=1, drops the strobes, and goes to DONE. A timed-out read writes back ERR_VALUE.
- DONE: stall=0 for this cycle. On a read, enable=1 with data = assembled word, zero-extended above 8*WORD_BYTES bits. On a write, enable stays 0. Always return to IDLE next cycle.
- A new SD instruction cannot start before IDLE is reached. Back-to-back SD instructions therefore leave one IDLE issue cycle between bursts.
- sd_ready already high on entry to REQ is taken as the acknowledge in that cycle. The RELEASE wait for sd_ready low prevents the next byte from seeing the previous acknowledge.
- Latency: if each acknowledge is high A cycles after the strobe and low R cycles after release, total stall = 1 + WORD_BYTES*(A+R+2) cycles, within ±1 per byte.
- Non-SD ops never touch the SD port or the enable output.

Test Plan:
- Read 4 bytes: READSD rs=0x100, rt-field=5; model returns 0x11,0x22,0x33,0x44 for 0x100..0x103 with A=3, R=2. Required: sd_addr steps 0x100..0x103, one enable pulse, addr=5, data=0x44332211, stall falls in the DONE cycle.
- Write 4 bytes: WRITESD rs=0x200, rt=0xA1B2C3D4. Required: bytes D4,C3,B2,A1 at 0x200..0x203; sd_read never high; enable never high.
- Sticky ready: model holds sd_ready high 5 cycles per byte. Required: exactly 4 byte transfers with no double-count; idx advances only after sd_ready falls.
- Timeout: TIMEOUT_W=4, sd_ready stuck 0. Required: after 15 cycles in REQ, err=1, strobes low, and data=0xFFFFFFFF written back to the rt-field register.
- Reset mid-burst: assert rst during byte 2 of a read. Required: sd_read low immediately, stall=0, no enable; the next READSD works normally.
- WORD_BYTES=1, non-SD op: run a non-SD op, then READSD returning 0x7E. Required: no stall on the non-SD op; data=0x0000007E; behaviour equivalent to the legacy single-byte block.
